// File: rtl/gpzda_sender_if.sv
// Byte/load link between a ZDA sentence requester and the sender.
// The sender takes the slave side; whoever starts sentences takes the master side.
interface gpzda_sender_if;
  logic        start;
  logic [7:0]  hour;
  logic [7:0]  minute;
  logic [7:0]  second;
  logic [7:0]  centisecond;
  logic [7:0]  day;
  logic [7:0]  month;
  logic [15:0] year;
  logic [7:0]  data;
  logic        load;
  logic        busy;
  logic        done;

  modport master (
    output start, hour, minute, second, centisecond, day, month, year,
    input  data, load, busy, done
  );

  modport slave (
    input  start, hour, minute, second, centisecond, day, month, year,
    output data, load, busy, done
  );
endinterface

// File: rtl/gpzda_sender.sv
// Streams one 34-byte NMEA ZDA sentence built from latched BCD fields,
// one load strobe per byte, PERIOD cycles apart.
module gpzda_sender #(
  parameter int PERIOD = 2
) (
  input logic           clock,
  input logic           reset,
  gpzda_sender_if.slave bus
);

  localparam int             PW          = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0]  PACE_RELOAD = PW'(PERIOD - 1);
  localparam logic [5:0]     LAST_IDX    = 6'd33;
  localparam logic [5:0]     END_IDX     = 6'd34;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state_r;
  logic [5:0]      idx_r;
  logic [PW-1:0]   pace_r;
  logic [7:0]      csum_r;
  logic [7:0]      hour_r;
  logic [7:0]      minute_r;
  logic [7:0]      second_r;
  logic [7:0]      centi_r;
  logic [7:0]      day_r;
  logic [7:0]      month_r;
  logic [15:0]     year_r;
  logic [7:0]      data_r;
  logic            load_r;
  logic            busy_r;
  logic            done_r;
  logic [7:0]      byte_s;
  logic            in_sum_s;

  assign bus.data = data_r;
  assign bus.load = load_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

  // BCD nibbles are not range-checked: 10-15 become ':'..'?'.
  function automatic logic [7:0] dig(input logic [3:0] n);
    return 8'h30 + {4'h0, n};
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end else begin
      return 8'h37 + {4'h0, n};
    end
  endfunction

  // Byte at the current frame index.
  always_comb begin
    byte_s = 8'h00;
    case (idx_r)
      6'd0:                                    byte_s = 8'h24;
      6'd1:                                    byte_s = 8'h47;
      6'd2:                                    byte_s = 8'h50;
      6'd3:                                    byte_s = 8'h5A;
      6'd4:                                    byte_s = 8'h44;
      6'd5:                                    byte_s = 8'h41;
      6'd6, 6'd16, 6'd19, 6'd22, 6'd27, 6'd28: byte_s = 8'h2C;
      6'd7:                                    byte_s = dig(hour_r[7:4]);
      6'd8:                                    byte_s = dig(hour_r[3:0]);
      6'd9:                                    byte_s = dig(minute_r[7:4]);
      6'd10:                                   byte_s = dig(minute_r[3:0]);
      6'd11:                                   byte_s = dig(second_r[7:4]);
      6'd12:                                   byte_s = dig(second_r[3:0]);
      6'd13:                                   byte_s = 8'h2E;
      6'd14:                                   byte_s = dig(centi_r[7:4]);
      6'd15:                                   byte_s = dig(centi_r[3:0]);
      6'd17:                                   byte_s = dig(day_r[7:4]);
      6'd18:                                   byte_s = dig(day_r[3:0]);
      6'd20:                                   byte_s = dig(month_r[7:4]);
      6'd21:                                   byte_s = dig(month_r[3:0]);
      6'd23:                                   byte_s = dig(year_r[15:12]);
      6'd24:                                   byte_s = dig(year_r[11:8]);
      6'd25:                                   byte_s = dig(year_r[7:4]);
      6'd26:                                   byte_s = dig(year_r[3:0]);
      6'd29:                                   byte_s = 8'h2A;
      6'd30:                                   byte_s = hex_char(csum_r[7:4]);
      6'd31:                                   byte_s = hex_char(csum_r[3:0]);
      6'd32:                                   byte_s = 8'h0D;
      6'd33:                                   byte_s = 8'h0A;
      default:                                 byte_s = 8'h00;
    endcase
  end

  assign in_sum_s = (idx_r >= 6'd1) && (idx_r <= 6'd28);

  // Sentence sequencer: latches fields on start, paces bytes, accumulates checksum.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      idx_r    <= 6'd0;
      pace_r   <= {PW{1'b0}};
      csum_r   <= 8'h00;
      hour_r   <= 8'h00;
      minute_r <= 8'h00;
      second_r <= 8'h00;
      centi_r  <= 8'h00;
      day_r    <= 8'h00;
      month_r  <= 8'h00;
      year_r   <= 16'h0000;
      data_r   <= 8'h00;
      load_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            hour_r   <= bus.hour;
            minute_r <= bus.minute;
            second_r <= bus.second;
            centi_r  <= bus.centisecond;
            day_r    <= bus.day;
            month_r  <= bus.month;
            year_r   <= bus.year;
            csum_r   <= 8'h00;
            data_r   <= 8'h24;
            load_r   <= 1'b1;
            idx_r    <= 6'd1;
            pace_r   <= PACE_RELOAD;
            busy_r   <= 1'b1;
            state_r  <= SEND;
          end else begin
            load_r <= 1'b0;
            busy_r <= 1'b0;
          end
        end
        SEND: begin
          // One idle cycle after the final byte so a new start lands two cycles later.
          if (idx_r == END_IDX) begin
            state_r <= IDLE;
            idx_r   <= 6'd0;
            pace_r  <= {PW{1'b0}};
            load_r  <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
          end else if (pace_r != {PW{1'b0}}) begin
            pace_r <= pace_r - PW'(1);
            load_r <= 1'b0;
            done_r <= 1'b0;
          end else begin
            data_r <= byte_s;
            load_r <= 1'b1;
            done_r <= (idx_r == LAST_IDX);
            idx_r  <= idx_r + 6'd1;
            pace_r <= PACE_RELOAD;
            if (in_sum_s) begin
              csum_r <= csum_r ^ byte_s;
            end else begin
              csum_r <= csum_r;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= 6'd0;
          pace_r  <= {PW{1'b0}};
          load_r  <= 1'b0;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpzda_sender.sv
// Directed bench for gpzda_sender: one instance with PERIOD=2, one with PERIOD=1,
// byte streams captured by negedge monitors and compared with hand-derived frames.
module tb_gpzda_sender;

  typedef logic [7:0] frame_t [34];

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  gpzda_sender_if ia ();
  gpzda_sender_if ib ();

  gpzda_sender #(.PERIOD(2)) dut_a (.clock(clock), .reset(reset), .bus(ia));
  gpzda_sender #(.PERIOD(1)) dut_b (.clock(clock), .reset(reset), .bus(ib));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         la[$];
  int         lb[$];
  int done_cnt_a = 0, done_cnt_b = 0, done_bad_a = 0, done_bad_b = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Capture every strobed byte with the cycle it appeared in.
  always @(negedge clock) begin
    if (ia.load) begin
      qa.push_back(ia.data);
      la.push_back(cyc);
    end
    if (ia.done) begin
      done_cnt_a <= done_cnt_a + 1;
      if (!ia.load || ia.data != 8'h0A) done_bad_a <= done_bad_a + 1;
    end
    if (ib.load) begin
      qb.push_back(ib.data);
      lb.push_back(cyc);
    end
    if (ib.done) begin
      done_cnt_b <= done_cnt_b + 1;
      if (!ib.load || ib.data != 8'h0A) done_bad_b <= done_bad_b + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  function automatic frame_t from_str(input string s);
    frame_t f;
    for (int i = 0; i < 32; i++) f[i] = s[i];
    f[32] = 8'h0D;
    f[33] = 8'h0A;
    return f;
  endfunction

  function automatic frame_t make_frame(input logic [7:0] hh, input logic [7:0] mm,
                                        input logic [7:0] ss, input logic [7:0] cc,
                                        input logic [7:0] dd, input logic [7:0] mo,
                                        input logic [15:0] yy);
    frame_t     f;
    string      hdr;
    logic [7:0] x;
    logic [3:0] nib [16];
    hdr = "$GPZDA,";
    for (int i = 0; i < 7; i++) f[i] = hdr[i];
    nib = '{hh[7:4], hh[3:0], mm[7:4], mm[3:0], ss[7:4], ss[3:0], cc[7:4], cc[3:0],
            dd[7:4], dd[3:0], mo[7:4], mo[3:0], yy[15:12], yy[11:8], yy[7:4], yy[3:0]};
    for (int i = 0; i < 6; i++) f[7 + i] = 8'h30 + {4'h0, nib[i]};
    f[13] = 8'h2E;
    f[14] = 8'h30 + {4'h0, nib[6]};
    f[15] = 8'h30 + {4'h0, nib[7]};
    f[16] = 8'h2C;
    f[17] = 8'h30 + {4'h0, nib[8]};
    f[18] = 8'h30 + {4'h0, nib[9]};
    f[19] = 8'h2C;
    f[20] = 8'h30 + {4'h0, nib[10]};
    f[21] = 8'h30 + {4'h0, nib[11]};
    f[22] = 8'h2C;
    for (int i = 0; i < 4; i++) f[23 + i] = 8'h30 + {4'h0, nib[12 + i]};
    f[27] = 8'h2C;
    f[28] = 8'h2C;
    x = 8'h00;
    for (int i = 1; i <= 28; i++) x = x ^ f[i];
    f[29] = 8'h2A;
    f[30] = hexc(x[7:4]);
    f[31] = hexc(x[3:0]);
    f[32] = 8'h0D;
    f[33] = 8'h0A;
    return f;
  endfunction

  task automatic set_fields(input bit use_b, input logic [7:0] hh, input logic [7:0] mm,
                            input logic [7:0] ss, input logic [7:0] cc, input logic [7:0] dd,
                            input logic [7:0] mo, input logic [15:0] yy);
    if (use_b) begin
      ib.hour = hh; ib.minute = mm; ib.second = ss; ib.centisecond = cc;
      ib.day = dd; ib.month = mo; ib.year = yy;
    end else begin
      ia.hour = hh; ia.minute = mm; ia.second = ss; ia.centisecond = cc;
      ia.day = dd; ia.month = mo; ia.year = yy;
    end
  endtask

  task automatic pulse_start(input bit use_b);
    if (use_b) ib.start = 1'b1; else ia.start = 1'b1;
    tick();
    if (use_b) ib.start = 1'b0; else ia.start = 1'b0;
  endtask

  task automatic wait_loads(input bit use_b, input int target, input int budget);
    int k;
    k = 0;
    while (((use_b ? qb.size() : qa.size()) < target) && (k < budget)) begin
      tick();
      k++;
    end
    check_eq("wait_loads_in_budget", ((use_b ? qb.size() : qa.size()) >= target), 1);
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k;
    k = 0;
    while ((done_cnt_a <= d0) && (k < budget)) begin
      tick();
      k++;
    end
    check_eq("wait_done_in_budget", (done_cnt_a > d0), 1);
  endtask

  task automatic check_frame(input string tag, input bit use_b, input int base, input frame_t exp);
    int         n;
    logic [7:0] g;
    n = use_b ? qb.size() : qa.size();
    check_eq({tag, "_len"}, (n >= base + 34), 1);
    for (int i = 0; i < 34; i++) begin
      g = 8'h00;
      if (base + i < n) g = use_b ? qb[base + i] : qa[base + i];
      check_eq($sformatf("%s_byte%0d", tag, i), g, exp[i]);
    end
  endtask

  initial begin
    string      s1;
    string      s0;
    frame_t     f1;
    frame_t     fm;
    int         base;
    int         c0;
    int         d0;
    bit         ok;
    logic [7:0] x;

    s1 = "$GPZDA,143042.00,25,08,2005,,*6E";
    s0 = "$GPZDA,000000.00,00,00,0000,,*";
    f1 = from_str(s1);
    reset = 1'b0;
    ia.start = 1'b0;
    ib.start = 1'b0;
    set_fields(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);
    set_fields(1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);
    repeat (3) tick();
    check_eq("rst_data", ia.data, 8'h00);
    check_eq("rst_load", ia.load, 1'b0);
    check_eq("rst_busy", ia.busy, 1'b0);
    check_eq("rst_done", ia.done, 1'b0);
    check_eq("rst_b_load", ib.load, 1'b0);
    reset = 1'b1;
    repeat (2) tick();

    // Scenario 1: reference sentence, PERIOD=2
    set_fields(1'b0, 8'h14, 8'h30, 8'h42, 8'h00, 8'h25, 8'h08, 16'h2005);
    base = qa.size();
    c0 = cyc;
    d0 = done_cnt_a;
    pulse_start(1'b0);
    check_eq("s1_busy_after_start", ia.busy, 1'b1);
    wait_loads(1'b0, base + 34, 200);
    repeat (6) tick();
    check_eq("s1_load_count", qa.size() - base, 34);
    check_eq("s1_latency", la[base] - c0, 1);
    check_frame("s1", 1'b0, base, f1);
    ok = 1'b1;
    for (int i = 1; i < 34; i++) if (la[base + i] - la[base + i - 1] != 2) ok = 1'b0;
    check_eq("s1_spacing2", ok, 1'b1);
    check_eq("s1_done_count", done_cnt_a - d0, 1);
    check_eq("s1_idle_busy", ia.busy, 1'b0);

    // Scenario 2: all-zero fields, checksum recomputed from the captured stream
    set_fields(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);
    base = qa.size();
    pulse_start(1'b0);
    wait_loads(1'b0, base + 34, 200);
    repeat (4) tick();
    for (int i = 0; i < 30; i++) check_eq($sformatf("s2_byte%0d", i), qa[base + i], s0[i]);
    x = 8'h00;
    for (int i = 1; i <= 28; i++) x = x ^ qa[base + i];
    check_eq("s2_xor_value", x, 8'h66);
    check_eq("s2_cks_hi", qa[base + 30], hexc(x[7:4]));
    check_eq("s2_cks_lo", qa[base + 31], hexc(x[3:0]));
    check_eq("s2_cr", qa[base + 32], 8'h0D);
    check_eq("s2_lf", qa[base + 33], 8'h0A);

    // Scenario 3a: start mid-frame and in the final-load cycle is ignored
    set_fields(1'b0, 8'h14, 8'h30, 8'h42, 8'h00, 8'h25, 8'h08, 16'h2005);
    base = qa.size();
    d0 = done_cnt_a;
    pulse_start(1'b0);
    repeat (20) tick();
    pulse_start(1'b0);
    wait_done(d0, 200);
    check_eq("s3_busy_final_cycle", ia.busy, 1'b1);
    pulse_start(1'b0);
    repeat (8) tick();
    check_eq("s3_ignored_count", qa.size() - base, 34);
    check_frame("s3a", 1'b0, base, f1);

    // Scenario 3b: start in the first busy=0 cycle gives a frame 2 cycles later
    base = qa.size();
    d0 = done_cnt_a;
    pulse_start(1'b0);
    wait_done(d0, 200);
    tick();
    check_eq("s3_first_idle_busy", ia.busy, 1'b0);
    pulse_start(1'b0);
    wait_loads(1'b0, base + 68, 200);
    repeat (6) tick();
    check_eq("s3_b2b_count", qa.size() - base, 68);
    check_eq("s3_b2b_gap", la[base + 34] - la[base + 33], 2);
    check_frame("s3b", 1'b0, base + 34, f1);

    // Scenario 4: inputs changed after acceptance do not leak into the frame
    base = qa.size();
    pulse_start(1'b0);
    set_fields(1'b0, 8'h23, 8'h59, 8'h58, 8'h99, 8'h31, 8'h12, 16'h1999);
    wait_loads(1'b0, base + 34, 200);
    repeat (4) tick();
    check_frame("s4", 1'b0, base, f1);

    // Scenario 5: async reset mid-frame, then a clean restart
    set_fields(1'b0, 8'h14, 8'h30, 8'h42, 8'h00, 8'h25, 8'h08, 16'h2005);
    base = qa.size();
    pulse_start(1'b0);
    wait_loads(1'b0, base + 15, 100);
    check_eq("s5_load_before_rst", ia.load, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_eq("s5_rst_load", ia.load, 1'b0);
    check_eq("s5_rst_busy", ia.busy, 1'b0);
    check_eq("s5_rst_done", ia.done, 1'b0);
    check_eq("s5_rst_data", ia.data, 8'h00);
    tick();
    reset = 1'b1;
    repeat (10) tick();
    check_eq("s5_no_loads_after_rst", qa.size() - base, 15);
    base = qa.size();
    pulse_start(1'b0);
    wait_loads(1'b0, base + 34, 200);
    repeat (4) tick();
    check_frame("s5", 1'b0, base, f1);

    // Scenario 6: PERIOD=1 streams back to back
    set_fields(1'b1, 8'h14, 8'h30, 8'h42, 8'h00, 8'h25, 8'h08, 16'h2005);
    base = qb.size();
    pulse_start(1'b1);
    wait_loads(1'b1, base + 34, 100);
    repeat (4) tick();
    check_eq("s6_load_count", qb.size() - base, 34);
    check_frame("s6", 1'b1, base, f1);
    ok = 1'b1;
    for (int i = 1; i < 34; i++) if (lb[base + i] - lb[base + i - 1] != 1) ok = 1'b0;
    check_eq("s6_consecutive", ok, 1'b1);

    // Scenario 6b: non-decimal nibble in hour (checksum 6E ^ 34 ^ 3A = 60)
    set_fields(1'b1, 8'h1A, 8'h30, 8'h42, 8'h00, 8'h25, 8'h08, 16'h2005);
    base = qb.size();
    pulse_start(1'b1);
    wait_loads(1'b1, base + 34, 100);
    repeat (4) tick();
    check_eq("s6_hex_digit", qb[base + 8], 8'h3A);
    check_eq("s6_cks_hi", qb[base + 30], 8'h36);
    check_eq("s6_cks_lo", qb[base + 31], 8'h30);
    fm = make_frame(8'h1A, 8'h30, 8'h42, 8'h00, 8'h25, 8'h08, 16'h2005);
    check_frame("s6b", 1'b1, base, fm);

    check_eq("done_only_with_lf_a", done_bad_a, 0);
    check_eq("done_only_with_lf_b", done_bad_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
